// File: rtl/rv_rtype_sequencer_pkg.sv
// Shared constants, ALU codes, decode helper and FSM state type for the
// R-type sequencer (package rv_ctrl_pkg).
package rv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE  = 7'h00;
    localparam logic [6:0] F7_ALT   = 7'h20;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_MUL = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_RESP   = 3'd4
    } state_e;

    typedef struct packed {
        logic       legal;
        logic [3:0] code;
    } alu_dec_t;

    // Maps a funct7/funct3 pair onto the ALU code; unknown pairs are flagged illegal.
    function automatic alu_dec_t decode_funct(input logic [6:0] f7, input logic [2:0] f3);
        alu_dec_t d;
        d.legal = 1'b1;
        d.code  = ALU_ADD;
        if (f7 == F7_ALT) begin
            if (f3 == 3'd0) begin
                d.code = ALU_SUB;
            end else begin
                d.legal = 1'b0;
            end
        end else if (f7 == F7_BASE) begin
            case (f3)
                3'd0:    d.code = ALU_ADD;
                3'd1:    d.code = ALU_SLL;
                3'd2:    d.code = ALU_MUL;
                3'd4:    d.code = ALU_XOR;
                3'd5:    d.code = ALU_SRL;
                3'd6:    d.code = ALU_OR;
                3'd7:    d.code = ALU_AND;
                default: d.legal = 1'b0;
            endcase
        end else begin
            d.legal = 1'b0;
        end
        return d;
    endfunction

    function automatic logic idx_in_range(input logic [4:0] idx, input int nregs);
        return (int'(idx) < nregs);
    endfunction

endpackage

// File: rtl/rv_rtype_sequencer_if.sv
// Instruction and result valid/ready channels of the R-type sequencer.
interface rv_rtype_sequencer_if #(parameter int XLEN = 16);
    logic            instr_valid_i;
    logic            instr_ready_o;
    logic [31:0]     instr_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [XLEN-1:0] res_data_o;
    logic [4:0]      res_rd_o;
    logic            res_illegal_o;

    modport slave (
        input  instr_valid_i, instr_i, res_ready_i,
        output instr_ready_o, res_valid_o, res_data_o, res_rd_o, res_illegal_o
    );

    modport master (
        output instr_valid_i, instr_i, res_ready_i,
        input  instr_ready_o, res_valid_o, res_data_o, res_rd_o, res_illegal_o
    );
endinterface

// File: rtl/rv_rtype_sequencer_alu.sv
// Combinational ALU for the R-type sequencer: wrapping arithmetic, logical shifts.
module rv_alu
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN = 16
) (
    input  logic [3:0]      alu_code_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o
);
    localparam int SW = $clog2(XLEN);

    // Result select; MUL keeps only the low XLEN bits of the product.
    always_comb begin
        y_o = '0;
        case (alu_code_i)
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_ADD: y_o = a_i + b_i;
            ALU_SLL: y_o = a_i << b_i[SW-1:0];
            ALU_SUB: y_o = a_i - b_i;
            ALU_SRL: y_o = a_i >> b_i[SW-1:0];
            ALU_MUL: y_o = a_i * b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            default: y_o = '0;
        endcase
    end
endmodule

// File: rtl/rv_rtype_sequencer.sv
// Multi-cycle R-type sequencer: FSM, local register file and result handshake.
// Optional macro PERF_CNT_EN adds retired/illegal handshake counters.
module rv_rtype_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN  = 16,
    parameter int NREGS = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    rv_rtype_sequencer_if.slave      bus,
    input  logic [$clog2(NREGS)-1:0] dbg_addr_i,
    output logic [XLEN-1:0]          dbg_data_o
`ifdef PERF_CNT_EN
    ,
    output logic [15:0]              retired_cnt_o,
    output logic [15:0]              illegal_cnt_o
`endif
);
    localparam int AW = $clog2(NREGS);

    state_e                      state_q, state_d;
    logic [31:0]                 instr_q, instr_d;
    logic [3:0]                  code_q, code_d;
    logic [XLEN-1:0]             res_data_q, res_data_d;
    logic [4:0]                  res_rd_q, res_rd_d;
    logic                        res_illegal_q, res_illegal_d;
    logic                        res_valid_q, res_valid_d;
    logic                        ready_q, ready_d;
    logic [NREGS-1:0][XLEN-1:0]  rf_q, rf_d;

    logic [4:0]      rs1_s, rs2_s, rd_s;
    alu_dec_t        dec_s;
    logic            legal_s;
    logic [XLEN-1:0] alu_y_s;
    logic            res_hs_s;

    assign rs1_s   = instr_q[19:15];
    assign rs2_s   = instr_q[24:20];
    assign rd_s    = instr_q[11:7];
    assign dec_s   = decode_funct(instr_q[31:25], instr_q[14:12]);
    assign legal_s = dec_s.legal && (instr_q[6:0] == OP_RTYPE) &&
                     idx_in_range(rs1_s, NREGS) && idx_in_range(rs2_s, NREGS) &&
                     idx_in_range(rd_s, NREGS);
    assign res_hs_s = res_valid_q && bus.res_ready_i;

    rv_alu #(.XLEN(XLEN)) u_alu (
        .alu_code_i (code_q),
        .a_i        (rf_q[rs1_s[AW-1:0]]),
        .b_i        (rf_q[rs2_s[AW-1:0]]),
        .y_o        (alu_y_s)
    );

    // Next-state, datapath capture and register-file write for one instruction at a time.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        code_d        = code_q;
        res_data_d    = res_data_q;
        res_rd_d      = res_rd_q;
        res_illegal_d = res_illegal_q;
        rf_d          = rf_q;
        case (state_q)
            S_IDLE: begin
                if (ready_q && bus.instr_valid_i) begin
                    instr_d = bus.instr_i;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                code_d   = dec_s.code;
                res_rd_d = rd_s;
                if (legal_s) begin
                    res_illegal_d = 1'b0;
                    state_d       = S_EXEC;
                end else begin
                    res_illegal_d = 1'b1;
                    res_data_d    = '0;
                    state_d       = S_RESP;
                end
            end
            S_EXEC: begin
                res_data_d = alu_y_s;
                state_d    = S_WB;
            end
            S_WB: begin
                if (rd_s != 5'd0) begin
                    rf_d[rd_s[AW-1:0]] = res_data_q;
                end else begin
                    rf_d = rf_q;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (res_hs_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Handshake flags are registered so both channels are driven straight from flops.
        ready_d     = (state_d == S_IDLE);
        res_valid_d = (state_d == S_RESP);
    end

    // State, datapath and register-file flops.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q       <= S_IDLE;
            instr_q       <= 32'd0;
            code_q        <= 4'd0;
            res_data_q    <= '0;
            res_rd_q      <= 5'd0;
            res_illegal_q <= 1'b0;
            res_valid_q   <= 1'b0;
            ready_q       <= 1'b0;
            rf_q          <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            code_q        <= code_d;
            res_data_q    <= res_data_d;
            res_rd_q      <= res_rd_d;
            res_illegal_q <= res_illegal_d;
            res_valid_q   <= res_valid_d;
            ready_q       <= ready_d;
            rf_q          <= rf_d;
        end
    end

    assign bus.instr_ready_o = ready_q;
    assign bus.res_valid_o   = res_valid_q;
    assign bus.res_data_o    = res_data_q;
    assign bus.res_rd_o      = res_rd_q;
    assign bus.res_illegal_o = res_illegal_q;
    assign dbg_data_o        = rf_q[dbg_addr_i];

`ifdef PERF_CNT_EN
    logic [15:0] retired_q, retired_d;
    logic [15:0] illegal_q, illegal_d;

    // Count result handshakes by kind; both wrap naturally at 16 bits.
    always_comb begin
        retired_d = retired_q;
        illegal_d = illegal_q;
        if (res_hs_s) begin
            if (res_illegal_q) begin
                illegal_d = illegal_q + 16'd1;
            end else begin
                retired_d = retired_q + 16'd1;
            end
        end else begin
            retired_d = retired_q;
            illegal_d = illegal_q;
        end
    end

    // Counter flops.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            retired_q <= 16'd0;
            illegal_q <= 16'd0;
        end else begin
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign retired_cnt_o = retired_q;
    assign illegal_cnt_o = illegal_q;
`endif

endmodule

// File: tb/tb_rv_rtype_sequencer.sv
// Self-checking bench for rv_rtype_sequencer (XLEN=16, NREGS=8): directed vector
// table, randomized instructions against a behavioural model, and a mid-flight reset.
module tb_rv_rtype_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mrf [8];

`ifdef PERF_CNT_EN
    logic [15:0] retired_cnt;
    logic [15:0] illegal_cnt;
`endif

    rv_rtype_sequencer_if #(.XLEN(16)) bus ();

    rv_rtype_sequencer #(.XLEN(16), .NREGS(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .bus        (bus),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
`ifdef PERF_CNT_EN
        ,
        .retired_cnt_o (retired_cnt),
        .illegal_cnt_o (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        int          stall;
        logic [15:0] data;
        logic [4:0]  rd;
        logic        ill;
        int          lat;
        logic [2:0]  dbg_idx;
        logic [15:0] dbg_val;
    } vec_t;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    // Reference behaviour: architectural effect of one instruction on the model register file.
    task automatic model(input logic [31:0] ins, output logic ill, output logic [15:0] d);
        int          rs1, rs2, rd;
        logic [15:0] a, b;
        logic [31:0] prod;
        rs1 = int'(ins[19:15]);
        rs2 = int'(ins[24:20]);
        rd  = int'(ins[11:7]);
        ill = (ins[6:0] != 7'b0110011) || (rs1 >= 8) || (rs2 >= 8) || (rd >= 8);
        a   = (rs1 < 8) ? mrf[rs1] : 16'h0000;
        b   = (rs2 < 8) ? mrf[rs2] : 16'h0000;
        prod = a * b;
        d   = 16'h0000;
        case ({ins[31:25], ins[14:12]})
            {7'h00, 3'd0}: d = a + b;
            {7'h20, 3'd0}: d = a - b;
            {7'h00, 3'd1}: d = a << b[3:0];
            {7'h00, 3'd2}: d = prod[15:0];
            {7'h00, 3'd4}: d = a ^ b;
            {7'h00, 3'd5}: d = a >> b[3:0];
            {7'h00, 3'd6}: d = a | b;
            {7'h00, 3'd7}: d = a & b;
            default:       ill = 1'b1;
        endcase
        if (ill) begin
            d = 16'h0000;
        end else if (rd != 0) begin
            mrf[rd] = d;
        end
    endtask

    // Called at a negedge; returns at the negedge after the result handshake.
    task automatic send(input logic [31:0] ins, input int stall,
                        output logic [15:0] d, output logic [4:0] rd, output logic ill,
                        output int lat, output logic held, output logic resumed);
        int n;
        held = 1'b1;
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = ins;
        n = 0;
        while (bus.instr_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n, 32'(n < 20), 32'd1);
        @(negedge clk);
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = $urandom();
        lat = 1;
        while (bus.res_valid_o !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d   = bus.res_data_o;
        rd  = bus.res_rd_o;
        ill = bus.res_illegal_o;
        if (bus.instr_ready_o !== 1'b0) held = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== d || bus.res_rd_o !== rd ||
                bus.res_illegal_o !== ill || bus.instr_ready_o !== 1'b0) held = 1'b0;
        end
        bus.res_ready_i = 1'b1;
        @(negedge clk);
        bus.res_ready_i = 1'b0;
        resumed = (bus.instr_ready_o === 1'b1) && (bus.res_valid_o === 1'b0);
    endtask

    initial begin
        vec_t        vec [18];
        logic [7:0][15:0] seed;
        logic [15:0] d, e_d;
        logic [4:0]  rd;
        logic        ill, e_ill, held, resumed, stale;
        logic [6:0]  f7, op;
        logic [2:0]  f3;
        logic [4:0]  i1, i2, i3;
        logic [31:0] ins;
        int          lat;

        rst_n = 1'b0;
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = 32'd0;
        bus.res_ready_i   = 1'b0;
        dbg_addr          = 3'd0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 0, 32'(bus.instr_ready_o), 32'd0);
        chk("rst_valid", 0, 32'(bus.res_valid_o), 32'd0);
        chk("rst_data", 0, 32'(bus.res_data_o), 32'd0);
        chk("rst_rd", 0, 32'(bus.res_rd_o), 32'd0);
        chk("rst_illegal", 0, 32'(bus.res_illegal_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 0, 32'(bus.instr_ready_o), 32'd1);

        // Every op on all-zero registers yields zero, so nonzero source values are seeded directly.
        seed    = '0;
        seed[5] = 16'h0100;
        seed[6] = 16'h0005;
        seed[7] = 16'h0003;
        for (int i = 0; i < 8; i++) mrf[i] = seed[i];
        force dut.rf_q = seed;
        @(negedge clk);
        release dut.rf_q;

        vec[0]  = '{enc(7'h00, 5'd0, 5'd6, 3'd0, 5'd1, 7'h33), 0, 16'h0005, 5'd1, 1'b0, 4, 3'd1, 16'h0005};
        vec[1]  = '{enc(7'h00, 5'd0, 5'd7, 3'd0, 5'd2, 7'h33), 0, 16'h0003, 5'd2, 1'b0, 4, 3'd2, 16'h0003};
        vec[2]  = '{enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 0, 16'h0008, 5'd3, 1'b0, 4, 3'd3, 16'h0008};
        vec[3]  = '{enc(7'h20, 5'd1, 5'd2, 3'd0, 5'd4, 7'h33), 0, 16'hFFFE, 5'd4, 1'b0, 4, 3'd4, 16'hFFFE};
        vec[4]  = '{enc(7'h00, 5'd5, 5'd5, 3'd2, 5'd5, 7'h33), 1, 16'h0000, 5'd5, 1'b0, 4, 3'd5, 16'h0000};
        vec[5]  = '{enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd4, 7'h13), 0, 16'h0000, 5'd4, 1'b1, 2, 3'd4, 16'hFFFE};
        vec[6]  = '{enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd2, 7'h33), 2, 16'h0000, 5'd2, 1'b1, 2, 3'd2, 16'h0003};
        vec[7]  = '{enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd1, 7'h33), 10, 16'h0008, 5'd1, 1'b0, 4, 3'd1, 16'h0008};
        vec[8]  = '{enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33), 0, 16'h000B, 5'd0, 1'b0, 4, 3'd0, 16'h0000};
        vec[9]  = '{enc(7'h00, 5'd2, 5'd7, 3'd1, 5'd6, 7'h33), 0, 16'h0018, 5'd6, 1'b0, 4, 3'd6, 16'h0018};
        vec[10] = '{enc(7'h00, 5'd2, 5'd4, 3'd5, 5'd7, 7'h33), 0, 16'h1FFF, 5'd7, 1'b0, 4, 3'd7, 16'h1FFF};
        vec[11] = '{enc(7'h00, 5'd1, 5'd4, 3'd4, 5'd2, 7'h33), 0, 16'hFFF6, 5'd2, 1'b0, 4, 3'd2, 16'hFFF6};
        vec[12] = '{enc(7'h00, 5'd7, 5'd6, 3'd6, 5'd5, 7'h33), 0, 16'h1FFF, 5'd5, 1'b0, 4, 3'd5, 16'h1FFF};
        vec[13] = '{enc(7'h00, 5'd6, 5'd4, 3'd7, 5'd3, 7'h33), 0, 16'h0018, 5'd3, 1'b0, 4, 3'd3, 16'h0018};
        vec[14] = '{enc(7'h00, 5'd1, 5'd2, 3'd0, 5'd8, 7'h33), 0, 16'h0000, 5'd8, 1'b1, 2, 3'd0, 16'h0000};
        vec[15] = '{enc(7'h00, 5'd1, 5'd9, 3'd0, 5'd1, 7'h33), 0, 16'h0000, 5'd1, 1'b1, 2, 3'd1, 16'h0008};
        vec[16] = '{enc(7'h00, 5'd1, 5'd2, 3'd3, 5'd6, 7'h33), 0, 16'h0000, 5'd6, 1'b1, 2, 3'd6, 16'h0018};
        vec[17] = '{enc(7'h20, 5'd1, 5'd2, 3'd1, 5'd7, 7'h33), 0, 16'h0000, 5'd7, 1'b1, 2, 3'd7, 16'h1FFF};

        for (int v = 0; v < 18; v++) begin
            model(vec[v].ins, e_ill, e_d);
            send(vec[v].ins, vec[v].stall, d, rd, ill, lat, held, resumed);
            chk("vec_data", v, 32'(d), 32'(vec[v].data));
            chk("vec_rd", v, 32'(rd), 32'(vec[v].rd));
            chk("vec_illegal", v, 32'(ill), 32'(vec[v].ill));
            chk("vec_latency", v, 32'(lat), 32'(vec[v].lat));
            chk("vec_hold", v, 32'(held), 32'd1);
            chk("vec_resume", v, 32'(resumed), 32'd1);
            dbg_addr = vec[v].dbg_idx;
            #1;
            chk("vec_dbg", v, 32'(dbg_data), 32'(vec[v].dbg_val));
        end

        for (int k = 0; k < 40; k++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0, 1:    f7 = 7'h20;
                2:       f7 = 7'($urandom());
                default: f7 = 7'h00;
            endcase
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom()) : 7'h33;
            i1 = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            i2 = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            i3 = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            ins = enc(f7, i2, i1, f3, i3, op);
            model(ins, e_ill, e_d);
            send(ins, $urandom_range(0, 3), d, rd, ill, lat, held, resumed);
            chk("rnd_data", k, 32'(d), 32'(e_d));
            chk("rnd_rd", k, 32'(rd), 32'(ins[11:7]));
            chk("rnd_illegal", k, 32'(ill), 32'(e_ill));
            chk("rnd_latency", k, 32'(lat), e_ill ? 32'd2 : 32'd4);
            chk("rnd_hold", k, 32'(held & resumed), 32'd1);
            dbg_addr = 3'($urandom_range(0, 7));
            #1;
            chk("rnd_dbg", k, 32'(dbg_data), 32'(mrf[dbg_addr]));
        end

        // Reset while the instruction is in EXEC: nothing may retire or be written back.
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = enc(7'h00, 5'd2, 5'd1, 3'd6, 5'd3, 7'h33);
        lat = 0;
        while (bus.instr_ready_o !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        bus.instr_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 0, 32'(bus.instr_ready_o), 32'd0);
        chk("midrst_valid", 0, 32'(bus.res_valid_o), 32'd0);
        chk("midrst_data", 0, 32'(bus.res_data_o), 32'd0);
        chk("midrst_rd", 0, 32'(bus.res_rd_o), 32'd0);
        chk("midrst_illegal", 0, 32'(bus.res_illegal_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0000;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.res_valid_o !== 1'b0) stale = 1'b1;
        end
        chk("midrst_no_stale", 0, 32'(stale), 32'd0);
        chk("midrst_ready_back", 0, 32'(bus.instr_ready_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk("midrst_rf_zero", i, 32'(dbg_data), 32'd0);
        end
        @(negedge clk);

`ifdef PERF_CNT_EN
        chk("cnt_rst_retired", 0, 32'(retired_cnt), 32'd0);
        chk("cnt_rst_illegal", 0, 32'(illegal_cnt), 32'd0);
        send(enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, 7'h33), 0, d, rd, ill, lat, held, resumed);
        send(enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, 7'h13), 1, d, rd, ill, lat, held, resumed);
        send(enc(7'h00, 5'd1, 5'd1, 3'd7, 5'd2, 7'h33), 0, d, rd, ill, lat, held, resumed);
        send(enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 2, d, rd, ill, lat, held, resumed);
        chk("cnt_retired", 0, 32'(retired_cnt), 32'd3);
        chk("cnt_illegal", 0, 32'(illegal_cnt), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_rtype_sequencer.md
Name: rv_rtype_sequencer

Overview:
Multi-cycle sequencer for the R-type decode/ALU datapath. Accepts one 32-bit instruction per valid/ready handshake and decodes funct7/funct3/opcode into the team's 4-bit ALU code. Reads a small local register file, executes, writes back and returns a result record over a second valid/ready handshake. Sits between the instruction source (wishbone/IO bridge) and the debug/observation outputs.

Parameters:
XLEN, 16, datapath and register width in bits (power of 2, at least 8)
NREGS, 8, register-file entries (power of 2, at most 32); x0 is hardwired to zero

Ports:
wb_clk_i  in  1  single clock, rising edge
wb_rst_ni  in  1  asynchronous reset, active-low
instr_valid_i  in  1  instruction offered
instr_ready_o  out  1  sequencer can accept an instruction
instr_i  in  32  instruction word {funct7, rs2, rs1, funct3, rd, opcode}
res_valid_o  out  1  result record valid
res_ready_i  in  1  consumer accepts result
res_data_o  out  XLEN  ALU result (0 when illegal)
res_rd_o  out  5  destination index of the retired instruction
res_illegal_o  out  1  instruction rejected; no writeback
dbg_addr_i  in  log2(NREGS)  register-file debug read index
dbg_data_o  out  XLEN  combinational read of rf[dbg_addr_i]

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; instr_ready_o=0 during reset, 1 first cycle after; res_valid_o=0, res_data_o=0, res_rd_o=0, res_illegal_o=0; all rf entries=0. Reset mid-operation drops the in-flight instruction, with no writeback and no result.
- FSM: IDLE -> DECODE -> EXEC -> WB -> RESP -> IDLE. DECODE -> RESP when illegal.
- IDLE: instr_ready_o=1 only here. Handshake (valid&ready at edge T) latches instr_i.
- DECODE (T+1): legality check and ALU code.
  - opcode must be 0110011, else illegal.
  - funct3/funct7 -> code: 0/0x00 ADD 0010; 0/0x20 SUB 0100; 1/0x00 SLL 0011; 2/0x00 MUL 0110; 4/0x00 XOR 0111; 5/0x00 SRL 0101; 6/0x00 OR 0001; 7/0x00 AND 0000.
  - Any other funct3/funct7 pair is illegal. Any rs1/rs2/rd index >= NREGS is illegal.
- EXEC (T+2): read rf[rs1], rf[rs2]; compute; register the result.
  - ADD/SUB/MUL keep the low XLEN bits (wrap, no flags). MUL is the low half of the unsigned product.
  - SLL/SRL shift rs1 by rs2[log2(XLEN)-1:0]; SRL is logical.
- WB (T+3): write rf[rd] if rd != 0; rd=0 discards the write but still retires normally.
- RESP: res_valid_o=1 from T+4 (legal) or T+2 (illegal). Hold data/rd/illegal stable until res_ready_i; return to IDLE on the handshake edge.
- Illegal response: res_data_o=0, res_illegal_o=1, res_rd_o=instr rd field.
- Latency: legal accept-to-valid 4 cycles; illegal 2 cycles. Maximum throughput is one instruction per 5 cycles with res_ready_i held high.
- No overlap: a new instruction is never accepted while one is in flight or pending in RESP.
- dbg read sees the write from WB on the following cycle (no bypass). dbg_data_o for index 0 is always 0.

Optional Feature:
Macro PERF_CNT_EN adds ports retired_cnt_o [15:0] and illegal_cnt_o [15:0].
- retired_cnt_o increments on each legal result handshake; illegal_cnt_o increments on each illegal result handshake.
- Both wrap 0xFFFF -> 0 and are cleared by reset.
- Without the macro, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package rv_ctrl_pkg: opcode constant OP_RTYPE, the 8 ALU code constants, funct7 constants F7_BASE/F7_ALT, and the FSM state enum.
- Sub-module rv_alu: combinational, takes the 4-bit code plus two XLEN operands and returns an XLEN result.
- Sequencer keeps the FSM, register file, handshakes and optional counters.

Test Plan:
- Preload via ops: ADDs produce x1=5, x2=3; then ADD x3,x1,x2 -> res_data=8, rd=3, valid 4 cycles after accept; dbg x3=8.
- SUB x4,x2,x1 (3-5) with XLEN=16 -> res_data=0xFFFE; MUL of 0x0100*0x0100 -> 0x0000 (wrap).
- opcode 0010011 -> res_illegal=1, res_data=0, valid 2 cycles after accept, rf unchanged; funct3=0/funct7=0x01 also illegal.
- res_ready_i low 10 cycles -> res_valid/res_data held stable, instr_ready_o=0 throughout; accept resumes the cycle after the handshake.
- ADD x0,x1,x2 -> retires with rd=0; dbg x0 stays 0.
- Reset asserted in EXEC -> outputs zero immediately; after release no stale result and rf all 0. With PERF_CNT_EN, 3 legal + 1 illegal -> counts 3/1.
